// File: rtl/read_packet_from_mem_pkg.sv
// Shared types and constants for the packet-buffer drain stage and its buffer.
package read_packet_from_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StData,
    StDrop,
    StIfg
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int unsigned DEFAULT_MAX_PACKET_LENGTH = 1536;

endpackage

// File: rtl/read_packet_from_mem.sv
// Drains stored packets from the buffer SRAM into a GMII-style tx stream
// (preamble, SFD, payload, IFG); out-of-range lengths are read out and discarded.
module read_packet_from_mem
  import read_packet_from_mem_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH        = 8,
  parameter int unsigned pLEN_WIDTH         = 16,
  parameter int unsigned pMAX_PACKET_LENGTH = DEFAULT_MAX_PACKET_LENGTH,
  parameter int unsigned pPREAMBLE_LEN      = 7,
  parameter int unsigned pIFG_LEN           = 12
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  input  logic                   iempty,
  input  logic [pLEN_WIDTH-1:0]  ilen_pac,
  output logic                   olen_pop,
  output logic                   ord_en,
  input  logic [pDATA_WIDTH-1:0] ir_data,
  output logic                   otx_en,
  output logic [pDATA_WIDTH-1:0] otx_d,
  output logic                   otx_last,
  output logic                   odrop,
  output logic                   obusy
);

  localparam logic [pLEN_WIDTH-1:0] LP_ONE      = pLEN_WIDTH'(1);
  localparam logic [pLEN_WIDTH-1:0] LP_MAX      = pLEN_WIDTH'(pMAX_PACKET_LENGTH);
  localparam logic [pLEN_WIDTH-1:0] LP_PRE_LAST = pLEN_WIDTH'(pPREAMBLE_LEN - 1);
  localparam logic [pLEN_WIDTH-1:0] LP_IFG_LAST = pLEN_WIDTH'(pIFG_LEN - 1);

  state_e                  r_state;
  logic [pLEN_WIDTH-1:0]   r_cnt;
  logic [pLEN_WIDTH-1:0]   r_len;
  logic                    r_tx_en;
  logic                    r_tx_sel;
  logic [pDATA_WIDTH-1:0]  r_tx_d;
  logic                    r_last;
  logic                    r_rd_en;
  logic                    r_drop;

  logic                    w_pop;
  logic [pLEN_WIDTH-1:0]   w_in_m1;
  logic [pLEN_WIDTH-1:0]   w_len_m1;

  // Pop is gated by reset so nothing leaves the FIFO while the buffer is being cleared.
  assign w_pop    = (r_state == StIdle) && !iempty && !i_rst;
  assign w_in_m1  = ilen_pac - LP_ONE;
  assign w_len_m1 = r_len - LP_ONE;

  // Counter holds "remaining cycles minus one" in the current state; zero means last cycle.
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_len    <= '0;
      r_tx_en  <= 1'b0;
      r_tx_sel <= 1'b0;
      r_tx_d   <= '0;
      r_last   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!iempty) begin
            r_len <= ilen_pac;
            if (ilen_pac == '0) begin
              r_drop <= 1'b1;
              r_cnt  <= '0;
            end else if (ilen_pac > LP_MAX) begin
              r_state <= StDrop;
              r_cnt   <= w_in_m1;
              r_rd_en <= 1'b1;
              r_drop  <= 1'b1;
            end else begin
              r_state <= StPreamble;
              r_cnt   <= LP_PRE_LAST;
              r_tx_en <= 1'b1;
              r_tx_d  <= pDATA_WIDTH'(PREAMBLE_BYTE);
            end
          end
        end
        StPreamble: begin
          if (r_cnt == '0) begin
            r_state <= StSfd;
            r_tx_d  <= pDATA_WIDTH'(SFD_BYTE);
            r_rd_en <= 1'b1;
          end else begin
            r_cnt <= r_cnt - LP_ONE;
          end
        end
        StSfd: begin
          // Payload is passed straight from SRAM; the read issued here lands in the first DATA cycle.
          r_state  <= StData;
          r_cnt    <= w_len_m1;
          r_tx_sel <= 1'b1;
          r_tx_d   <= '0;
          r_rd_en  <= (r_len != LP_ONE);
          r_last   <= (r_len == LP_ONE);
        end
        StData: begin
          if (r_cnt == '0) begin
            r_state  <= StIfg;
            r_cnt    <= LP_IFG_LAST;
            r_tx_en  <= 1'b0;
            r_tx_sel <= 1'b0;
            r_last   <= 1'b0;
            r_rd_en  <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - LP_ONE;
            r_rd_en <= (r_cnt != LP_ONE);
            r_last  <= (r_cnt == LP_ONE);
          end
        end
        StDrop: begin
          if (r_cnt == '0) begin
            r_state <= StIdle;
            r_rd_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt - LP_ONE;
          end
        end
        StIfg: begin
          if (r_cnt == '0) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - LP_ONE;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign olen_pop = w_pop;
  assign ord_en   = r_rd_en;
  assign otx_en   = r_tx_en;
  assign otx_d    = r_tx_sel ? ir_data : r_tx_d;
  assign otx_last = r_last;
  assign odrop    = r_drop;
  assign obusy    = (r_state != StIdle);

endmodule

// File: tb/tb_read_packet_from_mem.sv
// Randomized bench for read_packet_from_mem: FIFO/SRAM responders plus a
// packet-level reference model of the expected tx stream and read counts.
module tb_read_packet_from_mem;

  localparam int DW   = 8;
  localparam int LW   = 16;
  localparam int MAXL = 1536;
  localparam int PRE  = 7;
  localparam int IFG  = 12;
  localparam int MEMN = 4096;

  logic          iclk = 1'b0;
  logic          i_rst = 1'b1;
  logic          iempty = 1'b1;
  logic [LW-1:0] ilen_pac = '0;
  logic [DW-1:0] ir_data = '0;
  logic          olen_pop, ord_en, otx_en, otx_last, odrop, obusy;
  logic [DW-1:0] otx_d;

  read_packet_from_mem #(
    .pDATA_WIDTH(DW), .pLEN_WIDTH(LW), .pMAX_PACKET_LENGTH(MAXL),
    .pPREAMBLE_LEN(PRE), .pIFG_LEN(IFG)
  ) u_dut (
    .iclk(iclk), .i_rst(i_rst), .iempty(iempty), .ilen_pac(ilen_pac),
    .olen_pop(olen_pop), .ord_en(ord_en), .ir_data(ir_data), .otx_en(otx_en),
    .otx_d(otx_d), .otx_last(otx_last), .odrop(odrop), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] mem [MEMN];
  int rptr = 0;
  int pend_q[$];
  logic resp_pop, resp_rd;

  // Length FIFO (first-word-fall-through) and SRAM with one-cycle read latency.
  always @(posedge iclk) begin
    resp_pop = olen_pop;
    resp_rd  = ord_en;
    #1;
    if (resp_pop && pend_q.size() > 0) void'(pend_q.pop_front());
    if (resp_rd) begin
      ir_data = mem[rptr % MEMN];
      rptr++;
    end else begin
      ir_data = 8'($urandom);
    end
    iempty   = (pend_q.size() == 0);
    ilen_pac = iempty ? LW'($urandom) : LW'(pend_q[0]);
  end

  logic [7:0] tx_d_q[$];
  bit         tx_last_q[$];
  int         tx_cyc_q[$];
  int         pop_q[$];
  int         drop_q[$];
  int         rd_cyc_q[$];
  int         idle_bad = 0;
  int         busy_n = 0;
  int         busy_last = -1;

  always @(negedge iclk) begin
    cyc++;
    if (otx_en) begin
      tx_d_q.push_back(otx_d);
      tx_last_q.push_back(otx_last);
      tx_cyc_q.push_back(cyc);
    end
    if (!otx_en && (otx_d != '0 || otx_last)) idle_bad++;
    if (olen_pop) pop_q.push_back(cyc);
    if (odrop) drop_q.push_back(cyc);
    if (ord_en) rd_cyc_q.push_back(cyc);
    if (obusy) begin
      busy_n++;
      busy_last = cyc;
    end
  end

  logic [7:0] exp_d[$];
  bit         exp_last[$];
  int         exp_rd, exp_drop, exp_pop;

  task automatic tick();
    @(posedge iclk);
    #3;
  endtask

  task automatic clear_log();
    tx_d_q.delete(); tx_last_q.delete(); tx_cyc_q.delete();
    pop_q.delete(); drop_q.delete(); rd_cyc_q.delete();
    idle_bad = 0; busy_n = 0; busy_last = -1;
  endtask

  // Packet-level model: every nonzero length consumes that many SRAM bytes;
  // only lengths 1..MAXL appear on the wire as preamble, SFD and payload.
  task automatic model_build(input int lens[$], input int start_ptr);
    int p;
    p = start_ptr;
    exp_d.delete(); exp_last.delete();
    exp_rd = 0; exp_drop = 0; exp_pop = 0;
    foreach (lens[k]) begin
      exp_pop++;
      if (lens[k] == 0) begin
        exp_drop++;
      end else if (lens[k] > MAXL) begin
        exp_drop++;
      end else begin
        for (int i = 0; i < PRE; i++) begin
          exp_d.push_back(8'h55); exp_last.push_back(1'b0);
        end
        exp_d.push_back(8'hD5); exp_last.push_back(1'b0);
        for (int i = 0; i < lens[k]; i++) begin
          exp_d.push_back(mem[(p + i) % MEMN]);
          exp_last.push_back(i == lens[k] - 1);
        end
      end
      p += lens[k];
      exp_rd += lens[k];
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int quiet = 0;
    int k = 0;
    while (quiet < 3 && k < budget) begin
      tick();
      k++;
      if (pend_q.size() == 0 && !obusy && !olen_pop) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: still busy after %0d cycles, want idle", name, budget);
    end
  endtask

  task automatic test_reset();
    pend_q.push_back(5);
    tick(); tick();
    n_tests++;
    if ({olen_pop, ord_en, otx_en, otx_d, otx_last, odrop, obusy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pop=%b rd=%b en=%b d=%h last=%b drop=%b busy=%b, want all 0",
               olen_pop, ord_en, otx_en, otx_d, otx_last, odrop, obusy);
    end
    pend_q.delete();
    tick();
    i_rst = 1'b0;
    clear_log();
    repeat (10) tick();
    n_tests++;
    if (busy_n != 0 || pop_q.size() != 0 || rd_cyc_q.size() != 0 || tx_d_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%0d pops=%0d reads=%0d tx=%0d, want all 0",
               busy_n, pop_q.size(), rd_cyc_q.size(), tx_d_q.size());
    end
    n_tests++;
    if (idle_bad != 0) begin
      n_fail++; $display("FAIL reset_idle_d: %0d cycles with data while idle, want 0", idle_bad);
    end
  endtask

  task automatic test_single_64();
    int lens[$];
    int errs, n, t_pop, t_sfd, t_last;
    lens = '{64};
    clear_log();
    model_build(lens, rptr);
    pend_q.push_back(64);
    wait_done("single64", 400);
    errs = (tx_d_q.size() != exp_d.size());
    foreach (exp_d[i]) if (i < tx_d_q.size() && (tx_d_q[i] !== exp_d[i] || tx_last_q[i] !== exp_last[i])) errs++;
    n_tests++;
    if (errs != 0) begin
      n_fail++; $display("FAIL single64_stream: %0d errors, got %0d bytes, want %0d", errs, tx_d_q.size(), exp_d.size());
    end
    n_tests++;
    if (rd_cyc_q.size() != exp_rd || pop_q.size() != 1 || drop_q.size() != 0) begin
      n_fail++; $display("FAIL single64_counts: reads=%0d pops=%0d drops=%0d, want %0d 1 0",
                         rd_cyc_q.size(), pop_q.size(), drop_q.size(), exp_rd);
    end
    n = tx_cyc_q.size();
    t_pop  = pop_q.size() > 0 ? pop_q[0] : -1000;
    t_sfd  = n > PRE ? tx_cyc_q[PRE] : -1000;
    t_last = n > 0 ? tx_cyc_q[n-1] : -1000;
    n_tests++;
    if ((n > 0 ? tx_cyc_q[0] : -1000) - t_pop != 1) begin
      n_fail++; $display("FAIL single64_first_tx: offset %0d, want 1", (n > 0 ? tx_cyc_q[0] : -1000) - t_pop);
    end
    n_tests++;
    if (t_sfd - t_pop != PRE + 1 || t_last - t_pop != PRE + 1 + 64) begin
      n_fail++; $display("FAIL single64_timing: sfd at %0d last at %0d, want %0d %0d",
                         t_sfd - t_pop, t_last - t_pop, PRE + 1, PRE + 65);
    end
    n_tests++;
    if ((rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1) != t_sfd) begin
      n_fail++; $display("FAIL single64_first_read: cycle %0d, want %0d (SFD)",
                         rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1, t_sfd);
    end
    n_tests++;
    if (busy_last - t_last != IFG || idle_bad != 0) begin
      n_fail++; $display("FAIL single64_ifg: busy ends %0d after last, idle_bad=%0d, want %0d 0",
                         busy_last - t_last, idle_bad, IFG);
    end
  endtask

  task automatic test_back_to_back();
    int lens[$];
    int errs, t_last1, t_pre2;
    lens = '{60, 100};
    clear_log();
    model_build(lens, rptr);
    pend_q.push_back(60);
    pend_q.push_back(100);
    wait_done("b2b", 600);
    errs = (tx_d_q.size() != exp_d.size());
    foreach (exp_d[i]) if (i < tx_d_q.size() && (tx_d_q[i] !== exp_d[i] || tx_last_q[i] !== exp_last[i])) errs++;
    n_tests++;
    if (errs != 0) begin
      n_fail++; $display("FAIL b2b_stream: %0d errors, got %0d bytes, want %0d", errs, tx_d_q.size(), exp_d.size());
    end
    n_tests++;
    if (pop_q.size() != 2 || rd_cyc_q.size() != exp_rd) begin
      n_fail++; $display("FAIL b2b_counts: pops=%0d reads=%0d, want 2 %0d", pop_q.size(), rd_cyc_q.size(), exp_rd);
    end
    // 12 IFG cycles plus one IDLE (pop) cycle separate last byte and next preamble.
    t_last1 = tx_cyc_q.size() > PRE + 61 ? tx_cyc_q[PRE + 60] : -1000;
    t_pre2  = tx_cyc_q.size() > PRE + 61 ? tx_cyc_q[PRE + 61] : 1000;
    n_tests++;
    if (t_pre2 - t_last1 != IFG + 2 || (pop_q.size() > 1 ? pop_q[1] : -1) - t_last1 != IFG + 1) begin
      n_fail++; $display("FAIL b2b_spacing: preamble %0d pop %0d cycles after last, want %0d %0d",
                         t_pre2 - t_last1, (pop_q.size() > 1 ? pop_q[1] : -1) - t_last1, IFG + 2, IFG + 1);
    end
  endtask

  task automatic test_len0();
    clear_log();
    pend_q.push_back(0);
    wait_done("len0", 50);
    n_tests++;
    if (pop_q.size() != 1 || drop_q.size() != 1 ||
        (drop_q.size() > 0 ? drop_q[0] : 0) - (pop_q.size() > 0 ? pop_q[0] : 0) != 1) begin
      n_fail++; $display("FAIL len0_drop: pops=%0d drops=%0d, want 1 pop and drop one cycle later",
                         pop_q.size(), drop_q.size());
    end
    n_tests++;
    if (rd_cyc_q.size() != 0 || tx_d_q.size() != 0 || busy_n != 0) begin
      n_fail++; $display("FAIL len0_quiet: reads=%0d tx=%0d busy=%0d, want 0 0 0",
                         rd_cyc_q.size(), tx_d_q.size(), busy_n);
    end
  endtask

  task automatic test_len1();
    int lens[$];
    int errs;
    lens = '{1};
    clear_log();
    model_build(lens, rptr);
    pend_q.push_back(1);
    wait_done("len1", 100);
    errs = (tx_d_q.size() != exp_d.size());
    foreach (exp_d[i]) if (i < tx_d_q.size() && (tx_d_q[i] !== exp_d[i] || tx_last_q[i] !== exp_last[i])) errs++;
    n_tests++;
    if (errs != 0) begin
      n_fail++; $display("FAIL len1_stream: %0d errors, got %0d bytes, want %0d", errs, tx_d_q.size(), exp_d.size());
    end
    n_tests++;
    if (rd_cyc_q.size() != 1 || (tx_cyc_q.size() > PRE ? tx_cyc_q[PRE] : -1) != (rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -2)) begin
      n_fail++; $display("FAIL len1_read: %0d reads, want exactly 1 in the SFD cycle", rd_cyc_q.size());
    end
  endtask

  task automatic test_drop_boundary();
    int lens[$];
    int errs, p1, p2, tx_in, rd_in;
    lens = '{MAXL, MAXL + 1, 10};
    clear_log();
    model_build(lens, rptr);
    foreach (lens[i]) pend_q.push_back(lens[i]);
    wait_done("boundary", 5000);
    errs = (tx_d_q.size() != exp_d.size());
    foreach (exp_d[i]) if (i < tx_d_q.size() && (tx_d_q[i] !== exp_d[i] || tx_last_q[i] !== exp_last[i])) errs++;
    n_tests++;
    if (errs != 0) begin
      n_fail++; $display("FAIL boundary_stream: %0d errors, got %0d bytes, want %0d", errs, tx_d_q.size(), exp_d.size());
    end
    p1 = pop_q.size() > 2 ? pop_q[1] : 0;
    p2 = pop_q.size() > 2 ? pop_q[2] : 0;
    n_tests++;
    if (pop_q.size() != 3 || p2 - p1 != MAXL + 2) begin
      n_fail++; $display("FAIL boundary_next_pop: pops=%0d gap=%0d, want 3 %0d", pop_q.size(), p2 - p1, MAXL + 2);
    end
    n_tests++;
    if (drop_q.size() != 1 || (drop_q.size() > 0 ? drop_q[0] : 0) != p1 + 1) begin
      n_fail++; $display("FAIL boundary_drop: drops=%0d, want 1 at pop+1", drop_q.size());
    end
    tx_in = 0; rd_in = 0;
    foreach (tx_cyc_q[i]) if (tx_cyc_q[i] > p1 && tx_cyc_q[i] < p2) tx_in++;
    foreach (rd_cyc_q[i]) if (rd_cyc_q[i] > p1 && rd_cyc_q[i] < p2) rd_in++;
    n_tests++;
    if (tx_in != 0 || rd_in != MAXL + 1 || rd_cyc_q.size() != exp_rd) begin
      n_fail++; $display("FAIL boundary_drop_reads: tx=%0d reads=%0d total=%0d, want 0 %0d %0d",
                         tx_in, rd_in, rd_cyc_q.size(), MAXL + 1, exp_rd);
    end
  endtask

  task automatic test_random();
    int lens[$];
    int errs, r;
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) lens.push_back(0);
      else if (r == 1) lens.push_back(1);
      else if (r == 2) lens.push_back(MAXL + $urandom_range(1, 40));
      else lens.push_back($urandom_range(2, 120));
    end
    clear_log();
    model_build(lens, rptr);
    foreach (lens[i]) begin
      pend_q.push_back(lens[i]);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) tick();
    end
    wait_done("random", 20000);
    errs = (tx_d_q.size() != exp_d.size());
    foreach (exp_d[i]) if (i < tx_d_q.size() && (tx_d_q[i] !== exp_d[i] || tx_last_q[i] !== exp_last[i])) errs++;
    n_tests++;
    if (errs != 0) begin
      n_fail++; $display("FAIL random_stream: %0d errors, got %0d bytes, want %0d", errs, tx_d_q.size(), exp_d.size());
    end
    n_tests++;
    if (rd_cyc_q.size() != exp_rd || drop_q.size() != exp_drop || pop_q.size() != exp_pop || idle_bad != 0) begin
      n_fail++; $display("FAIL random_counts: reads=%0d drops=%0d pops=%0d idle_bad=%0d, want %0d %0d %0d 0",
                         rd_cyc_q.size(), drop_q.size(), pop_q.size(), idle_bad, exp_rd, exp_drop, exp_pop);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_log();
    pend_q.push_back(200);
    while (tx_d_q.size() < PRE + 1 + 49 && k < 400) begin
      tick();
      k++;
    end
    n_tests++;
    if (otx_en !== 1'b1 || !ord_en) begin
      n_fail++; $display("FAIL reset_mid_pre: en=%b rd=%b at byte 50, want 1 1", otx_en, ord_en);
    end
    i_rst = 1'b1;
    pend_q.delete();
    rptr = 0;
    #1;
    n_tests++;
    if ({olen_pop, ord_en, otx_en, otx_d, otx_last, odrop, obusy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got pop=%b rd=%b en=%b d=%h last=%b drop=%b busy=%b, want all 0",
               olen_pop, ord_en, otx_en, otx_d, otx_last, odrop, obusy);
    end
    tick(); tick();
    i_rst = 1'b0;
    clear_log();
    repeat (20) tick();
    n_tests++;
    if (busy_n != 0 || rd_cyc_q.size() != 0 || tx_d_q.size() != 0 || pop_q.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_after: busy=%0d reads=%0d tx=%0d pops=%0d, want all 0",
                         busy_n, rd_cyc_q.size(), tx_d_q.size(), pop_q.size());
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'($urandom);
    test_reset();
    test_single_64();
    test_back_to_back();
    test_len0();
    test_len1();
    test_drop_boundary();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
